store_rmw_unit: RTL and testbench

STORE_RMW_UNIT -- requirements
Module: store_rmw_unit

---
 rtl/store_pkg.sv | 22 ++
 rtl/store_lane_merge.sv | 36 +++
 rtl/store_rmw_unit.sv | 145 ++++++++++++++
 tb/tb_store_rmw_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types for the store read-modify-write unit: size encoding, FSM states
// and the default data width.
package store_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge: overlays the store data onto the old memory
// word starting at the given lane, for the number of bytes implied by size.
module store_lane_merge
  import store_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0]           old_word,
  input  logic [XLEN-1:0]           data,
  input  size_e                     size,
  input  logic [$clog2(XLEN/8)-1:0] lane,
  output logic [XLEN-1:0]           merged
);

  localparam int NB = XLEN / 8;

  int lane_i;
  int nbytes;

  always_comb begin
    merged = old_word;
    lane_i = int'(lane);
    case (size)
      SZ_B:    nbytes = 1;
      SZ_H:    nbytes = 2;
      SZ_W:    nbytes = 4;
      default: nbytes = NB;
    endcase
    for (int i = 0; i < NB; i++) begin
      if (i >= lane_i && i < lane_i + nbytes) begin
        merged[i*8 +: 8] = data[(i-lane_i)*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit performing read-modify-write for sub-word stores and a direct
// write for full-width stores. Optional macro STORE_MISALIGN_CHECK_EN rejects misaligned stores.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [XLEN-1:0]   req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic              mem_rd_valid,
  input  logic [XLEN-1:0]   mem_rd_data,
  output logic              mem_wr_en,
  output logic [XLEN-1:0]   mem_wr_data,
  output logic              done,
  output logic              misaligned
);

  localparam int LANE_W = $clog2(XLEN / 8);

  state_e              state;
  state_e              state_nx;
  size_e               req_sz;
  size_e               size_q;
  logic                full_req;
  logic                accept;
  logic [LANE_W-1:0]   lane_req;
  logic [LANE_W-1:0]   lane_q;
  logic [XLEN-1:0]     data_q;
  logic [XLEN-1:0]     merged;

  // A dword on a 32-bit datapath behaves as a word; lane rounds down to a size multiple.
  always_comb begin
    req_sz = size_e'(req_size);
    if (XLEN == 32 && req_sz == SZ_D) req_sz = SZ_W;
    full_req = (XLEN == 32) ? (req_sz == SZ_W) : (req_sz == SZ_D);
    lane_req = req_addr[LANE_W-1:0];
    case (req_sz)
      SZ_H:    lane_req[0]   = 1'b0;
      SZ_W:    lane_req[1:0] = 2'b00;
      default: ;
    endcase
  end

`ifdef STORE_MISALIGN_CHECK_EN
  logic misalign_req;

  always_comb begin
    case (req_sz)
      SZ_H:    misalign_req = req_addr[0];
      SZ_W:    misalign_req = |req_addr[1:0];
      SZ_D:    misalign_req = |req_addr[2:0];
      default: misalign_req = 1'b0;
    endcase
  end
`endif

  assign accept = req_valid && (state == ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (full_req) state_nx = ST_WRITE;
          else          state_nx = ST_READ;
`ifdef STORE_MISALIGN_CHECK_EN
          if (misalign_req) state_nx = ST_ERR;
`endif
        end
      end
      ST_READ: begin
        mem_rd_en = 1'b1;
        state_nx  = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rd_valid) state_nx = ST_WRITE;
      end
      ST_WRITE: begin
        mem_wr_en = 1'b1;
        done      = 1'b1;
        state_nx  = ST_IDLE;
      end
`ifdef STORE_MISALIGN_CHECK_EN
      ST_ERR: begin
        misaligned = 1'b1;
        state_nx   = ST_IDLE;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request capture: outputs visible to memory are cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr    <= '0;
      mem_wr_data <= '0;
    end else begin
      if (accept) begin
        mem_addr <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
        if (full_req) mem_wr_data <= req_data;
      end else if (state == ST_WAIT && mem_rd_valid) begin
        mem_wr_data <= merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= req_data;
      size_q <= req_sz;
      lane_q <= lane_req;
    end
  end

  store_lane_merge #(
    .XLEN(XLEN)
  ) u_merge (
    .old_word(mem_rd_data),
    .data    (data_q),
    .size    (size_q),
    .lane    (lane_q),
    .merged  (merged)
  );

endmodule

// File: tb/tb_store_rmw_unit.sv
// Self-checking bench for store_rmw_unit: one 32-bit and one 64-bit instance,
// directed vector table, hand sequences for reset/back-to-back, random stores.
module tb_store_rmw_unit;

`ifdef STORE_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_rd_en, a_rvalid, a_wr_en, a_done, a_mis;
  logic [31:0] a_addr, a_maddr, a_data, a_rdata, a_wdata;
  logic [1:0]  a_size;

  logic        b_valid, b_ready, b_rd_en, b_rvalid, b_wr_en, b_done, b_mis;
  logic [31:0] b_addr, b_maddr;
  logic [63:0] b_data, b_rdata, b_wdata;
  logic [1:0]  b_size;

  store_rmw_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_addr(a_addr), .req_size(a_size), .req_data(a_data),
    .mem_addr(a_maddr), .mem_rd_en(a_rd_en), .mem_rd_valid(a_rvalid),
    .mem_rd_data(a_rdata), .mem_wr_en(a_wr_en), .mem_wr_data(a_wdata),
    .done(a_done), .misaligned(a_mis)
  );

  store_rmw_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_addr(b_addr), .req_size(b_size), .req_data(b_data),
    .mem_addr(b_maddr), .mem_rd_en(b_rd_en), .mem_rd_valid(b_rvalid),
    .mem_rd_data(b_rdata), .mem_wr_en(b_wr_en), .mem_wr_data(b_wdata),
    .done(b_done), .misaligned(b_mis)
  );

  typedef struct {
    logic        ready, rd_en, wr_en, done, mis;
    logic [63:0] wdata;
    logic [31:0] maddr;
  } obs_t;

  typedef struct {
    bit          w;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic [63:0] rd;
    int          dly;
    bit          full;
    bit          err;
    logic [63:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input bit w, input logic v, input logic [31:0] ad,
                           input logic [1:0] sz, input logic [63:0] d);
    if (w) begin
      b_valid = v; b_addr = ad; b_size = sz; b_data = d;
    end else begin
      a_valid = v; a_addr = ad; a_size = sz; a_data = d[31:0];
    end
  endtask

  task automatic drive_rd(input bit w, input logic v, input logic [63:0] d);
    if (w) begin
      b_rvalid = v; b_rdata = d;
    end else begin
      a_rvalid = v; a_rdata = d[31:0];
    end
  endtask

  task automatic sample(input bit w, output obs_t o);
    if (w) begin
      o.ready = b_ready; o.rd_en = b_rd_en; o.wr_en = b_wr_en; o.done = b_done;
      o.mis = b_mis; o.wdata = b_wdata; o.maddr = b_maddr;
    end else begin
      o.ready = a_ready; o.rd_en = a_rd_en; o.wr_en = a_wr_en; o.done = a_done;
      o.mis = a_mis; o.wdata = {32'h0, a_wdata}; o.maddr = a_maddr;
    end
  endtask

  // Reference: byte-mask arithmetic over the store footprint.
  function automatic void model(input bit w, input logic [31:0] addr, input logic [1:0] size,
                                input logic [63:0] data, input logic [63:0] rd,
                                output logic [63:0] exp, output bit full, output bit mis);
    int nb, n, k;
    logic [63:0] mask;
    nb = w ? 8 : 4;
    n = 1 << size;
    if (n > nb) n = nb;
    full = (n == nb);
    mis = (addr % n) != 0;
    k = int'(addr % nb);
    k = k - (k % n);
    if (full) exp = data;
    else begin
      mask = ((64'd1 << (8*n)) - 64'd1) << (8*k);
      exp = (rd & ~mask) | ((data << (8*k)) & mask);
    end
    if (!w) exp = exp & 64'hFFFF_FFFF;
  endfunction

  task automatic do_store(input bit w, input logic [31:0] addr, input logic [1:0] size,
                          input logic [63:0] data, input logic [63:0] rd, input int dly,
                          input bit noise, output logic [63:0] wr, output logic [31:0] ma,
                          output int lat, output int rdc, output bit err, output bit wr_seen,
                          output bit dn, output bit ovl, output bit ok, output bit rdy0);
    obs_t o;
    int rd_at;
    @(negedge clk);
    sample(w, o);
    rdy0 = o.ready;
    drive_req(w, 1'b1, addr, size, data);
    @(negedge clk);
    drive_req(w, 1'b0, 32'h0, 2'd0, 64'h0);
    rd_at = -1; ok = 0; wr = '0; ma = '0; lat = 0; rdc = 0;
    err = 0; wr_seen = 0; dn = 0; ovl = 0;
    for (int c = 1; c <= 60; c++) begin
      sample(w, o);
      if (o.rd_en && o.wr_en) ovl = 1;
      if (o.rd_en) begin rdc++; rd_at = c + dly; end
      if (o.wr_en) begin wr_seen = 1; wr = o.wdata; ma = o.maddr; lat = c; dn = o.done; ok = 1; end
      if (o.mis) begin err = 1; lat = c; ok = 1; end
      if (ok) break;
      if (c == rd_at)             drive_rd(w, 1'b1, rd);
      else if (noise && o.rd_en)  drive_rd(w, 1'b1, ~rd);
      else                        drive_rd(w, 1'b0, 64'h0);
      @(negedge clk);
    end
    drive_rd(w, 1'b0, 64'h0);
  endtask

  task automatic run_check(input string nm, input bit w, input logic [31:0] addr,
                           input logic [1:0] size, input logic [63:0] data, input logic [63:0] rd,
                           input int dly, input bit noise, input bit full, input bit experr,
                           input logic [63:0] exp);
    logic [63:0] wr;
    logic [31:0] ma;
    int lat, rdc;
    bit err, wr_seen, dn, ovl, ok, rdy0;
    do_store(w, addr, size, data, rd, dly, noise, wr, ma, lat, rdc, err, wr_seen, dn, ovl, ok, rdy0);
    check({nm, "_ready_before"}, 64'(rdy0), 64'd1);
    check({nm, "_completed"}, 64'(ok), 64'd1);
    if (experr) begin
      check({nm, "_misaligned"}, 64'(err), 64'd1);
      check({nm, "_err_lat"}, 64'(lat), 64'd1);
      check({nm, "_err_rd"}, 64'(rdc), 64'd0);
      check({nm, "_err_wr"}, 64'(wr_seen), 64'd0);
    end else begin
      check({nm, "_wdata"}, wr, exp);
      check({nm, "_maddr"}, 64'(ma), 64'(addr & (w ? ~32'd7 : ~32'd3)));
      check({nm, "_latency"}, 64'(lat), full ? 64'd1 : 64'(dly + 2));
      check({nm, "_rd_count"}, 64'(rdc), full ? 64'd0 : 64'd1);
      check({nm, "_done"}, 64'(dn), 64'd1);
      check({nm, "_overlap"}, 64'(ovl), 64'd0);
      check({nm, "_no_mis"}, 64'(err), 64'd0);
    end
  endtask

  vec_t tbl[9];

  initial begin
    obs_t o;
    logic [63:0] exp, d, r;
    bit full, mis;
    int hits, d1, acc2, nwr, rd_at;
    bit ovl;
    logic [63:0] w1, w2;
    logic [31:0] m2;

    rst = 1'b1;
    drive_req(0, 1'b0, 32'h0, 2'd0, 64'h0);
    drive_req(1, 1'b0, 32'h0, 2'd0, 64'h0);
    drive_rd(0, 1'b0, 64'h0);
    drive_rd(1, 1'b0, 64'h0);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      sample(w[0], o);
      check("reset_ready", 64'(o.ready), 64'd1);
      check("reset_strobes", {60'h0, o.rd_en, o.wr_en, o.done, o.mis}, 64'h0);
      check("reset_maddr", 64'(o.maddr), 64'h0);
      check("reset_wdata", o.wdata, 64'h0);
    end
    rst = 1'b0;

    tbl[0] = '{0, 32'h1002, 2'd0, 64'hAB, 64'h11223344, 2, 0, 0, 64'h11AB3344};
    tbl[1] = '{0, 32'h20, 2'd2, 64'hDEADBEEF, 64'h0, 1, 1, 0, 64'hDEADBEEF};
    tbl[2] = '{1, 32'h6, 2'd1, 64'hCAFE, 64'h0123456789ABCDEF, 1, 0, 0, 64'hCAFE456789ABCDEF};
`ifdef STORE_MISALIGN_CHECK_EN
    tbl[3] = '{0, 32'h3, 2'd1, 64'hCAFE, 64'h11223344, 1, 0, 1, 64'h0};
`else
    tbl[3] = '{0, 32'h3, 2'd1, 64'hCAFE, 64'h11223344, 1, 0, 0, 64'hCAFE3344};
`endif
    tbl[4] = '{1, 32'h7, 2'd0, 64'h5A, 64'h0123456789ABCDEF, 3, 0, 0, 64'h5A23456789ABCDEF};
    tbl[5] = '{1, 32'h4, 2'd2, 64'h11223344, 64'h0123456789ABCDEF, 1, 0, 0, 64'h1122334489ABCDEF};
    tbl[6] = '{1, 32'h40, 2'd3, 64'hFEDCBA9876543210, 64'h0, 1, 1, 0, 64'hFEDCBA9876543210};
    tbl[7] = '{0, 32'h2, 2'd1, 64'hBEEF, 64'h11223344, 4, 0, 0, 64'hBEEF3344};
    tbl[8] = '{0, 32'h8, 2'd3, 64'hA5A5A5A5, 64'h0, 1, 1, 0, 64'hA5A5A5A5};

    foreach (tbl[i]) begin
      run_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].addr, tbl[i].size, tbl[i].data,
                tbl[i].rd, tbl[i].dly, 1'b1, tbl[i].full, tbl[i].err, tbl[i].exp);
    end

    // Reset while waiting for read data: the late read response must not cause a write.
    @(negedge clk);
    drive_req(0, 1'b1, 32'h301, 2'd0, 64'h77);
    @(negedge clk);
    drive_req(0, 1'b0, 32'h0, 2'd0, 64'h0);
    sample(0, o);
    check("rstwait_read", 64'(o.rd_en), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    sample(0, o);
    check("rstwait_ready", 64'(o.ready), 64'd1);
    check("rstwait_strobes", {61'h0, o.rd_en, o.wr_en, o.done}, 64'h0);
    check("rstwait_maddr", 64'(o.maddr), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_rd(0, 1'b1, 64'h12345678);
    @(negedge clk);
    drive_rd(0, 1'b0, 64'h0);
    hits = 0;
    repeat (4) begin
      sample(0, o);
      if (o.wr_en || o.done) hits++;
      @(negedge clk);
    end
    check("rstwait_no_write", 64'(hits), 64'd0);
    sample(0, o);
    check("rstwait_ready_after", 64'(o.ready), 64'd1);

    // Back-to-back byte stores with req_valid held high.
    drive_req(0, 1'b1, 32'h100, 2'd0, 64'h11);
    d1 = -1; acc2 = -1; nwr = 0; rd_at = -1; ovl = 0; w1 = '0; w2 = '0; m2 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      sample(0, o);
      if (c == 1) drive_req(0, 1'b1, 32'h105, 2'd0, 64'h22);
      if (o.rd_en && o.wr_en) ovl = 1;
      if (o.rd_en) rd_at = c + 1;
      if (c == rd_at) drive_rd(0, 1'b1, 64'h55667788);
      else            drive_rd(0, 1'b0, 64'h0);
      if (o.ready && d1 >= 0 && acc2 < 0) acc2 = c;
      if (o.wr_en) begin
        nwr++;
        if (nwr == 1) begin d1 = c; w1 = o.wdata; end
        else begin
          w2 = o.wdata; m2 = o.maddr;
          drive_req(0, 1'b0, 32'h0, 2'd0, 64'h0);
          drive_rd(0, 1'b0, 64'h0);
          break;
        end
      end
    end
    drive_req(0, 1'b0, 32'h0, 2'd0, 64'h0);
    check("b2b_writes", 64'(nwr), 64'd2);
    check("b2b_accept_gap", 64'(acc2 - d1), 64'd1);
    check("b2b_wdata1", w1, 64'h55667711);
    check("b2b_wdata2", w2, 64'h55662288);
    check("b2b_maddr2", 64'(m2), 64'h104);
    check("b2b_overlap", 64'(ovl), 64'd0);

    // Random stores on both widths against the mask model.
    for (int i = 0; i < 60; i++) begin
      bit w;
      logic [31:0] ad;
      logic [1:0] sz;
      w  = i[0];
      ad = $urandom;
      sz = 2'($urandom_range(0, 3));
      d  = {32'($urandom), 32'($urandom)};
      r  = {32'($urandom), 32'($urandom)};
      if (!w) begin d = d & 64'hFFFF_FFFF; r = r & 64'hFFFF_FFFF; end
      model(w, ad, sz, d, r, exp, full, mis);
      run_check($sformatf("rnd%0d", i), w, ad, sz, d, r, $urandom_range(1, 4),
                1'($urandom_range(0, 1)), full, MIS_EN && mis, exp);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
